// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and default widths for the memory port arbiter
package mem_pkg;

  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 64;
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_F    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signals of the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;
  logic              f_err;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  logic [ADDR_W-1:0] memAddress;
  logic              readEN;
  logic              writeEn;
  logic [DATA_W-1:0] valueWrite;
  logic [DATA_W-1:0] valueRead;
  logic              dmemError;
  logic              busy;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, valueRead, dmemError,
    output f_ack, f_rdata, f_err, d_ack, d_rdata, d_err,
    output memAddress, readEN, writeEn, valueWrite, busy
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, valueRead, dmemError,
    input  f_ack, f_rdata, f_err, d_ack, d_rdata, d_err,
    input  memAddress, readEN, writeEn, valueWrite, busy
  );
endinterface

// File: rtl/mem_port_arbiter_streak_ctr.sv
// rtl/mem_port_arbiter_streak_ctr.sv - saturating count of data grants made while fetch waits
module arb_streak_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_max_o
);
  import mem_pkg::*;

  localparam logic [STREAK_W-1:0] MAX_C = STREAK_W'(MAX);

  logic [STREAK_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max_o = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data stages
// Every access runs IDLE -> ACCESS -> RESP; data wins unless fetch has waited MAX_DSTREAK grants.
module mem_port_arbiter #(
  parameter int ADDR_W      = mem_pkg::ADDR_W,
  parameter int DATA_W      = mem_pkg::DATA_W,
  parameter int MAX_DSTREAK = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  import mem_pkg::*;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              f_ack_q, f_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              f_err_q, f_err_d;
  logic              d_err_q, d_err_d;
  logic              at_max, grant_f, streak_inc, streak_clr;

  arb_streak_ctr #(.MAX(MAX_DSTREAK)) u_streak (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (streak_clr),
    .inc_i    (streak_inc),
    .at_max_o (at_max)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    f_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;
    f_err_d    = f_err_q;
    d_err_d    = d_err_q;
    streak_inc = 1'b0;
    streak_clr = 1'b0;
    grant_f    = bus.f_req && (!bus.d_req || at_max);

    case (state_q)
      ST_IDLE: begin
        if (bus.f_req || bus.d_req) begin
          state_d = ST_ACCESS;
          if (grant_f) begin
            owner_d    = OWN_F;
            addr_d     = bus.f_addr;
            rd_d       = 1'b1;
            wr_d       = 1'b0;
            wdata_d    = '0;
            streak_clr = 1'b1;
          end else begin
            owner_d    = OWN_D;
            addr_d     = bus.d_addr;
            rd_d       = !bus.d_we;
            wr_d       = bus.d_we;
            wdata_d    = bus.d_we ? bus.d_wdata : '0;
            streak_inc = bus.f_req;
            streak_clr = !bus.f_req;
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        addr_d  = '0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        wdata_d = '0;
        if (owner_q == OWN_F) begin
          f_rdata_d = bus.valueRead;
          f_err_d   = bus.dmemError;
          f_ack_d   = 1'b1;
        end else if (owner_q == OWN_D) begin
          // A write returns no data, so the last read result stays visible.
          if (!wr_q) begin
            d_rdata_d = bus.valueRead;
          end
          d_err_d = bus.dmemError;
          d_ack_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      f_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      f_ack_q   <= f_ack_d;
      d_ack_q   <= d_ack_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
      f_err_q   <= f_err_d;
      d_err_q   <= d_err_d;
    end
  end

  assign bus.f_ack      = f_ack_q;
  assign bus.f_rdata    = f_rdata_q;
  assign bus.f_err      = f_err_q;
  assign bus.d_ack      = d_ack_q;
  assign bus.d_rdata    = d_rdata_q;
  assign bus.d_err      = d_err_q;
  assign bus.memAddress = addr_q;
  assign bus.readEN     = rd_q;
  assign bus.writeEn    = wr_q;
  assign bus.valueWrite = wdata_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule
